// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage RV32I pipeline: load-use bubbles, branch flushes and memory-wait stalls with watchdog.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_ID,
  input  logic [31:0] instr_EX,
  input  logic        rd_wren_EX,
  input  logic        br_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ack,
  output logic        stall_PC,
  output logic        stall_IFID,
  output logic        stall_IDEX,
  output logic        stall_EXMEM,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic        flush_MEMWB,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             timeout;

  logic [6:0] opc_ID, opc_EX;
  logic [4:0] rd_EX, rs1_ID, rs2_ID;
  logic       rs1_used, rs2_used, load_use;

  assign opc_ID = instr_ID[6:0];
  assign opc_EX = instr_EX[6:0];
  assign rd_EX  = instr_EX[11:7];
  assign rs1_ID = instr_ID[19:15];
  assign rs2_ID = instr_ID[24:20];

  assign rs1_used = !(opc_ID == OPC_LUI || opc_ID == OPC_AUIPC || opc_ID == OPC_JAL);
  assign rs2_used = (opc_ID == OPC_R) || (opc_ID == OPC_S) || (opc_ID == OPC_B);

  assign load_use = (opc_EX == OPC_LOAD) && rd_wren_EX && (rd_EX != 5'd0) &&
                    ((rs1_used && (rs1_ID == rd_EX)) || (rs2_used && (rs2_ID == rd_EX)));

  // Timeout fires on the last permitted wait cycle; the abort itself is the following cycle.
  assign timeout = (state == MEM_WAIT) && !mem_ack &&
                   (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  logic unused_bits;
  assign unused_bits = ^{instr_ID[31:25], instr_ID[14:7], instr_EX[31:12]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_next  = state;
    stall_PC    = 1'b0;
    stall_IFID  = 1'b0;
    stall_IDEX  = 1'b0;
    stall_EXMEM = 1'b0;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_MEMWB = 1'b0;

    if (rst) begin
      state_next  = RUN;
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      flush_MEMWB = 1'b1;
    end else if (mem_err_q) begin
      // Watchdog abort: drop the stuck access and restart the front end.
      state_next  = RUN;
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      flush_MEMWB = 1'b1;
    end else if (state == MEM_WAIT && !mem_ack) begin
      stall_PC    = 1'b1;
      stall_IFID  = 1'b1;
      stall_IDEX  = 1'b1;
      stall_EXMEM = 1'b1;
      flush_MEMWB = 1'b1;
      if (timeout) state_next = RUN;
    end else begin
      state_next = RUN;
      if (mem_req_MEM && !mem_ack) begin
        state_next  = MEM_WAIT;
        stall_PC    = 1'b1;
        stall_IFID  = 1'b1;
        stall_IDEX  = 1'b1;
        stall_EXMEM = 1'b1;
        flush_MEMWB = 1'b1;
      end else if (br_taken_EX) begin
        flush_IFID = 1'b1;
        flush_IDEX = 1'b1;
      end else if (load_use) begin
        stall_PC   = 1'b1;
        stall_IFID = 1'b1;
        flush_IDEX = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      mem_err_q <= timeout;
      if (state == MEM_WAIT && state_next == MEM_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall_PC && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle model pushes expected strobes as stimulus is driven,
// and the negedge checker pops and compares them against the DUT.
module tb_hazard_ctrl;

  localparam int unsigned T = 4;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LW_X5     = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] LW_X0     = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD_X5    = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] ADD_X0    = {7'd0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI_F5    = {20'h00028, 5'd5, 7'b0110111};
  localparam logic [31:0] SW_X5     = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] ADDI_IMM5 = {12'd5, 5'd1, 3'b000, 5'd6, 7'b0010011};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_ID, instr_EX;
  logic        rd_wren_EX, br_taken_EX, mem_req_MEM, mem_ack;
  logic        stall_PC, stall_IFID, stall_IDEX, stall_EXMEM;
  logic        flush_IFID, flush_IDEX, flush_MEMWB, mem_err;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .instr_ID(instr_ID), .instr_EX(instr_EX),
    .rd_wren_EX(rd_wren_EX), .br_taken_EX(br_taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX),
    .stall_EXMEM(stall_EXMEM), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .flush_MEMWB(flush_MEMWB), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [7:0]  strobes;  // {sPC,sIFID,sIDEX,sEXMEM,fIFID,fIDEX,fMEMWB,mem_err}
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   n_vec  = 0;
  int   n_miss = 0;

  bit          m_wait;
  int          m_waited;
  bit          m_err;
  logic [31:0] m_perf;

  logic [6:0] opcs [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_lu(input logic [31:0] id, input logic [31:0] ex, input logic wren);
    bit u1, u2;
    case (id[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: u1 = 1'b0;
      default:                            u1 = 1'b1;
    endcase
    case (id[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: u2 = 1'b1;
      default:                            u2 = 1'b0;
    endcase
    return (ex[6:0] == 7'b0000011) && wren && (ex[11:7] != 5'd0) &&
           ((u1 && id[19:15] == ex[11:7]) || (u2 && id[24:20] == ex[11:7]));
  endfunction

  task automatic drive(input logic r, input logic [31:0] id, input logic [31:0] ex,
                       input logic wren, input logic br, input logic req, input logic ack);
    exp_t e;
    bit sp, sif, sid, sem, fif, fid, fmw, to;
    @(posedge clk);
    #1;
    rst = r; instr_ID = id; instr_EX = ex;
    rd_wren_EX = wren; br_taken_EX = br; mem_req_MEM = req; mem_ack = ack;

    {sp, sif, sid, sem, fif, fid, fmw} = '0;
    if (r || m_err)              {fif, fid, fmw} = 3'b111;
    else if (m_wait && !ack)     {sp, sif, sid, sem, fmw} = 5'b11111;
    else if (req && !ack)        {sp, sif, sid, sem, fmw} = 5'b11111;
    else if (br)                 {fif, fid} = 2'b11;
    else if (is_lu(id, ex, wren)) {sp, sif, fid} = 3'b111;

    e.strobes = {sp, sif, sid, sem, fif, fid, fmw, m_err};
`ifdef HAZARD_PERF_EN
    e.cnt = m_perf;
`else
    e.cnt = 32'd0;
`endif
    sb.push_back(e);

    if (r) begin
      m_wait = 0; m_waited = 0; m_err = 0; m_perf = '0;
    end else begin
      if (sp && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
      to = 0;
      if (m_err) begin
        m_wait = 0; m_waited = 0;
      end else if (m_wait && !ack) begin
        m_waited++;
        if (m_waited == int'(T)) begin to = 1; m_wait = 0; m_waited = 0; end
      end else if (m_wait) begin
        m_wait = 0; m_waited = 0;
      end else if (req && !ack) begin
        m_wait = 1;
      end
      m_err = to;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, NOP, NOP, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_pop = sb.pop_front();
      check("strobes", {24'd0, stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
                        flush_IFID, flush_IDEX, flush_MEMWB, mem_err}, {24'd0, e_pop.strobes});
      check("stall_cnt", stall_cnt, e_pop.cnt);
    end
  end

  initial begin
    rst = 1'b1; instr_ID = NOP; instr_EX = NOP;
    rd_wren_EX = 0; br_taken_EX = 0; mem_req_MEM = 0; mem_ack = 0;
    m_wait = 0; m_waited = 0; m_err = 0; m_perf = '0;
    repeat (2) @(posedge clk);

    // Reset dominates every hazard source
    drive(1, ADD_X5, LW_X5, 1, 1, 1, 0);
    drive(1, NOP, NOP, 0, 0, 0, 0);
    idle(1);

    // Load-use variants
    drive(0, ADD_X5, LW_X5, 1, 0, 0, 0);
    idle(1);
    drive(0, ADD_X0, LW_X0, 1, 0, 0, 0);
    drive(0, ADD_X5, LW_X5, 0, 0, 0, 0);
    drive(0, LUI_F5, LW_X5, 1, 0, 0, 0);
    drive(0, SW_X5, LW_X5, 1, 0, 0, 0);
    drive(0, ADDI_IMM5, LW_X5, 1, 0, 0, 0);

    // Branch beats load-use
    drive(0, ADD_X5, LW_X5, 1, 1, 0, 0);
    idle(1);

    // Memory wait: three stalled cycles then ack, branch ignored while waiting
    drive(0, NOP, NOP, 0, 0, 1, 0);
    drive(0, ADD_X5, LW_X5, 1, 1, 1, 0);
    drive(0, NOP, NOP, 0, 0, 1, 0);
    drive(0, NOP, NOP, 0, 0, 1, 1);
    idle(1);

    // Ack in the request cycle
    drive(0, NOP, NOP, 0, 0, 1, 1);
    idle(1);

    // Watchdog expiry with request held
    for (int i = 0; i < 6; i++) drive(0, NOP, NOP, 0, 0, 1, 0);
    idle(2);

    // Ack on the timeout cycle wins
    for (int i = 0; i < 4; i++) drive(0, NOP, NOP, 0, 0, 1, 0);
    drive(0, NOP, NOP, 0, 0, 1, 1);
    idle(2);

    // Reset in the middle of a wait
    for (int i = 0; i < 3; i++) drive(0, NOP, NOP, 0, 0, 1, 0);
    drive(1, NOP, NOP, 0, 0, 1, 0);
    drive(1, NOP, NOP, 0, 0, 1, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  rd, r1, r2;
      logic [31:0] id, ex;
      rd = 5'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      ex = ($urandom_range(0, 2) != 0) ? {12'd0, 5'd1, 3'b010, rd, 7'b0000011}
                                       : {7'd0, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
      id = {7'd0, r2, r1, 3'b000, 5'd6, opcs[$urandom_range(0, 7)]};
      drive(($urandom_range(0, 59) == 0), id, ex, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
